// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MemManager bus.
// Holds DEPTH words and answers read/write requests with a four-phase
// request/done handshake, after WAIT_CYC wait states. The shared data bus
// is driven only while read_dn is high.
// Optional build macro: MEM_RESP_BADADDR_EN adds the bad_addr output, which
// flags transactions whose latched address is outside 0..DEPTH-1.
module mem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 128,
    parameter int WAIT_CYC = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read_q,
    input  logic              write_q,
    inout  wire  [DATA_W-1:0] data,
    output logic              read_dn,
    output logic              write_dn,
    output logic              busy
`ifdef MEM_RESP_BADADDR_EN
    ,
    output logic              bad_addr
`endif
);

    // Index width; a one-word memory still needs a one-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address limit widened by one bit so DEPTH itself is representable.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

    // The wait counter is four bits wide; WAIT_CYC is limited to 0..15.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t              state_reg,    state_next;
    logic [3:0]          cnt_reg,      cnt_next;
    logic                op_write_reg, op_write_next;
    logic [ADDR_W-1:0]   addr_reg,     addr_next;
    logic [DATA_W-1:0]   wdata_reg,    wdata_next;
    logic                read_dn_reg,  read_dn_next;
    logic                write_dn_reg, write_dn_next;
    logic                bad_reg,      bad_next;

    // Word storage and its registered read port. Neither is reset: memory
    // contents survive RESET, and rdata_reg is only observed behind read_dn.
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_reg;

    logic                in_range;
    logic                wait_done;
    logic                req_held;
    logic [IDX_W-1:0]    mem_idx;
    logic                mem_we;
    logic                mem_re;

    // The range check uses the full latched address, so upper bits can
    // never alias onto a low word; the index is only used once in range.
    assign in_range  = ({1'b0, addr_reg} < ADDR_LIMIT);
    assign mem_idx   = addr_reg[IDX_W-1:0];
    assign wait_done = (cnt_reg == WAIT_LAST);

    // The request that matches the operation currently being acknowledged.
    assign req_held  = op_write_reg ? write_q : read_q;

    // Memory access happens on the edge that enters ACK.
    assign mem_we = (state_reg == ST_WAIT) && wait_done &&  op_write_reg && in_range;
    assign mem_re = (state_reg == ST_WAIT) && wait_done && !op_write_reg;

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_write_next = op_write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        read_dn_next  = read_dn_reg;
        write_dn_next = write_dn_reg;
        bad_next      = bad_reg;

        case (state_reg)
            ST_IDLE: begin
                // Read wins when both requests are present.
                if (read_q) begin
                    addr_next     = addr;
                    op_write_next = 1'b0;
                    cnt_next      = 4'd0;
                    state_next    = ST_WAIT;
                end else if (write_q) begin
                    addr_next     = addr;
                    wdata_next    = data;
                    op_write_next = 1'b1;
                    cnt_next      = 4'd0;
                    state_next    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wait_done) begin
                    state_next    = ST_ACK;
                    read_dn_next  = !op_write_reg;
                    write_dn_next =  op_write_reg;
                    bad_next      = !in_range;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_ACK: begin
                // Done is held until the requester lets go; a request that
                // was dropped early simply ends ACK on the first edge.
                if (!req_held) begin
                    read_dn_next  = 1'b0;
                    write_dn_next = 1'b0;
                    bad_next      = 1'b0;
                    state_next    = ST_REL;
                end
            end

            ST_REL: begin
                // One turnaround cycle; any pending request waits for IDLE.
                state_next = ST_IDLE;
            end

            default: begin
                state_next    = ST_IDLE;
                read_dn_next  = 1'b0;
                write_dn_next = 1'b0;
                bad_next      = 1'b0;
            end
        endcase
    end

    // Control and handshake registers; RESET aborts any transaction at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            read_dn_reg  <= 1'b0;
            write_dn_reg <= 1'b0;
            bad_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            read_dn_reg  <= read_dn_next;
            write_dn_reg <= write_dn_next;
            bad_reg      <= bad_next;
        end
    end

    // Word array write and registered read, kept reset-free for RAM mapping.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_reg;
        end
        if (mem_re) begin
            rdata_reg <= mem[mem_idx];
        end
    end

    // Out-of-range reads return zeros; the bus is released outside read_dn.
    assign data     = read_dn_reg ? (bad_reg ? '0 : rdata_reg) : 'z;

    assign read_dn  = read_dn_reg;
    assign write_dn = write_dn_reg;
    assign busy     = (state_reg != ST_IDLE);

`ifdef MEM_RESP_BADADDR_EN
    assign bad_addr = bad_reg;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: checks two responders side by side, one with one wait
// state (index 1) and one with none (index 0). A pull-up on each bus makes
// a released bus read as all ones, so random data avoids that value.
module tb_mem_responder;

    localparam int DEPTH = 128;
    localparam int W0    = 0;
    localparam int W1    = 1;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    logic [31:0] addr_t [2];
    logic        rq_t   [2];
    logic        wq_t   [2];
    logic [31:0] drv_t  [2];
    logic        den_t  [2];
    logic        rdn    [2];
    logic        wdn    [2];
    logic        bsy    [2];
    logic        bad_o  [2];
    logic [31:0] bus_v  [2];
    wire  [31:0] data0;
    wire  [31:0] data1;

    logic [31:0] model [2][DEPTH];

    int total   = 0;
    int bad_cnt = 0;

    pullup (data0);
    pullup (data1);
    assign data0    = den_t[0] ? drv_t[0] : 'z;
    assign data1    = den_t[1] ? drv_t[1] : 'z;
    assign bus_v[0] = data0;
    assign bus_v[1] = data1;

`ifndef MEM_RESP_BADADDR_EN
    assign bad_o[0] = 1'b0;
    assign bad_o[1] = 1'b0;
`endif

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(W0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .addr(addr_t[0]), .read_q(rq_t[0]), .write_q(wq_t[0]),
        .data(data0), .read_dn(rdn[0]), .write_dn(wdn[0]), .busy(bsy[0])
`ifdef MEM_RESP_BADADDR_EN
        , .bad_addr(bad_o[0])
`endif
    );

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(W1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .addr(addr_t[1]), .read_q(rq_t[1]), .write_q(wq_t[1]),
        .data(data1), .read_dn(rdn[1]), .write_dn(wdn[1]), .busy(bsy[1])
`ifdef MEM_RESP_BADADDR_EN
        , .bad_addr(bad_o[1])
`endif
    );

    // Edges from raising a request until its done is seen (accept edge included).
    function automatic int exp_lat(input int s);
        return ((s == 1) ? W1 : W0) + 2;
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'hFFFF_FFFF) v = 32'h0;
        return v;
    endfunction

    // One full handshake; returns observations, makes no judgement.
    task automatic xact(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic badf,
                        output logic other, output logic dn_after, output logic [31:0] bus_after,
                        output logic busy_rel, output logic busy_after);
        addr_t[s] = a;
        other = 1'b0;
        if (wr) begin
            drv_t[s] = wd;
            den_t[s] = 1'b1;
            wq_t[s]  = 1'b1;
        end else begin
            rq_t[s] = 1'b1;
        end
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (wr ? rdn[s] : wdn[s]) other = 1'b1;
        end while (!(wr ? wdn[s] : rdn[s]) && lat < 50);
        rd   = bus_v[s];
        badf = bad_o[s];
        rq_t[s]  = 1'b0;
        wq_t[s]  = 1'b0;
        den_t[s] = 1'b0;
        @(posedge CLK); #1;
        dn_after  = rdn[s] | wdn[s];
        bus_after = bus_v[s];
        busy_rel  = bsy[s];
        @(posedge CLK); #1;
        busy_after = bsy[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            addr_t[s] = '0; rq_t[s] = 1'b0; wq_t[s] = 1'b0; drv_t[s] = '0; den_t[s] = 1'b0;
        end
        RESET = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        for (int s = 0; s < 2; s++) begin
            total++; if (rdn[s] !== 1'b0) begin bad_cnt++; $display("FAIL reset_read_dn[%0d]: got %b want 0", s, rdn[s]); end
            total++; if (wdn[s] !== 1'b0) begin bad_cnt++; $display("FAIL reset_write_dn[%0d]: got %b want 0", s, wdn[s]); end
            total++; if (bsy[s] !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy[%0d]: got %b want 0", s, bsy[s]); end
            total++; if (bus_v[s] !== 32'hFFFF_FFFF) begin bad_cnt++; $display("FAIL reset_bus_released[%0d]: got %h want ffffffff", s, bus_v[s]); end
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_fill();
        logic [31:0] v, rd, bo; int lat; logic bf, ot, da, br, ba;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = rnd();
                if (s == 1 && i == 4) v = 32'h0000_00A5;
                if (s == 1 && i == 3) v = 32'hDEAD_BEEF;
                if (s == 1 && i == 9) v = 32'h0;
                xact(s, 1'b1, i, v, rd, lat, bf, ot, da, bo, br, ba);
                model[s][i] = v;
                total++;
                if (lat !== exp_lat(s) || ot !== 1'b0 || da !== 1'b0) begin
                    bad_cnt++;
                    $display("FAIL fill_write[%0d][%0d]: latency %0d other %b dn_after %b want latency %0d 0 0", s, i, lat, ot, da, exp_lat(s));
                end
            end
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] rd, bo; int lat; logic bf, ot, da, br, ba;
        xact(1, 1'b0, 32'd4, '0, rd, lat, bf, ot, da, bo, br, ba);
        total++; if (lat !== 3) begin bad_cnt++; $display("FAIL read_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'h0000_00A5) begin bad_cnt++; $display("FAIL read_data: got %h want 000000a5", rd); end
        total++; if (ot !== 1'b0) begin bad_cnt++; $display("FAIL read_no_write_dn: got %b want 0", ot); end
        total++; if (da !== 1'b0) begin bad_cnt++; $display("FAIL read_dn_drop: got %b want 0", da); end
        total++; if (bo !== 32'hFFFF_FFFF) begin bad_cnt++; $display("FAIL read_bus_release: got %h want ffffffff", bo); end
        total++; if (br !== 1'b1) begin bad_cnt++; $display("FAIL read_busy_in_rel: got %b want 1", br); end
        total++; if (ba !== 1'b0) begin bad_cnt++; $display("FAIL read_busy_idle: got %b want 0", ba); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, bo; int lat; logic bf, ot, da, br, ba;
        xact(1, 1'b1, 32'd7, 32'h1234_5678, rd, lat, bf, ot, da, bo, br, ba);
        model[1][7] = 32'h1234_5678;
        total++; if (lat !== 3) begin bad_cnt++; $display("FAIL write_latency: got %0d want 3", lat); end
        total++; if (ot !== 1'b0) begin bad_cnt++; $display("FAIL write_no_read_dn: got %b want 0", ot); end
        total++; if (ba !== 1'b0) begin bad_cnt++; $display("FAIL write_busy_idle: got %b want 0", ba); end
        xact(1, 1'b0, 32'd7, '0, rd, lat, bf, ot, da, bo, br, ba);
        total++; if (rd !== 32'h1234_5678) begin bad_cnt++; $display("FAIL write_readback: got %h want 12345678", rd); end
    endtask

    task automatic test_priority();
        logic [31:0] nv, rd, got, bo; int n, lat; logic saw_w, ot, bf, da, br, ba;
        nv = rnd();
        addr_t[1] = 32'd3; drv_t[1] = nv; den_t[1] = 1'b0;
        rq_t[1] = 1'b1; wq_t[1] = 1'b1;
        n = 0; saw_w = 1'b0;
        do begin
            @(posedge CLK); #1; n++;
            if (wdn[1]) saw_w = 1'b1;
        end while (!rdn[1] && n < 50);
        got = bus_v[1];
        total++; if (n !== 3) begin bad_cnt++; $display("FAIL prio_read_latency: got %0d want 3", n); end
        total++; if (got !== 32'hDEAD_BEEF) begin bad_cnt++; $display("FAIL prio_read_data: got %h want deadbeef", got); end
        rq_t[1] = 1'b0;
        n = 0; ot = 1'b0;
        do begin
            @(posedge CLK); #1; n++;
            if (rdn[1]) ot = 1'b1;
            if (n == 1) den_t[1] = 1'b1;
        end while (!wdn[1] && n < 50);
        total++; if (n !== 5) begin bad_cnt++; $display("FAIL prio_write_after_rel: got %0d edges want 5", n); end
        total++; if (saw_w !== 1'b0 || ot !== 1'b0) begin bad_cnt++; $display("FAIL prio_exclusive_dn: write_dn_early %b read_dn_late %b want 0 0", saw_w, ot); end
        wq_t[1] = 1'b0; den_t[1] = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        model[1][3] = nv;
        xact(1, 1'b0, 32'd3, '0, rd, lat, bf, ot, da, bo, br, ba);
        total++; if (rd !== nv) begin bad_cnt++; $display("FAIL prio_write_commit: got %h want %h", rd, nv); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd, bo, sum, exp_sum; int lat; logic bf, ot, da, br, ba;
        logic [31:0] bad_list [4];
        bad_list[0] = 32'd200; bad_list[1] = 32'd128; bad_list[2] = 32'h8000_0004; bad_list[3] = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            xact(1, 1'b0, bad_list[k], '0, rd, lat, bf, ot, da, bo, br, ba);
            total++;
            if (rd !== 32'h0 || lat !== 3 || da !== 1'b0) begin
                bad_cnt++;
                $display("FAIL badaddr_read[%h]: data %h latency %0d dn_after %b want 0 3 0", bad_list[k], rd, lat, da);
            end
`ifdef MEM_RESP_BADADDR_EN
            total++; if (bf !== 1'b1) begin bad_cnt++; $display("FAIL badaddr_flag_read[%h]: got %b want 1", bad_list[k], bf); end
`endif
        end
        for (int k = 0; k < 4; k++) begin
            xact(1, 1'b1, bad_list[k], rnd(), rd, lat, bf, ot, da, bo, br, ba);
            total++; if (lat !== 3) begin bad_cnt++; $display("FAIL badaddr_write_latency[%h]: got %0d want 3", bad_list[k], lat); end
`ifdef MEM_RESP_BADADDR_EN
            total++; if (bf !== 1'b1) begin bad_cnt++; $display("FAIL badaddr_flag_write[%h]: got %b want 1", bad_list[k], bf); end
`endif
        end
        sum = '0; exp_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            xact(1, 1'b0, i, '0, rd, lat, bf, ot, da, bo, br, ba);
            sum = sum + rd;
            exp_sum = exp_sum + model[1][i];
`ifdef MEM_RESP_BADADDR_EN
            if (i == 0) begin
                total++; if (bf !== 1'b0) begin bad_cnt++; $display("FAIL badaddr_flag_inrange: got %b want 0", bf); end
            end
`endif
        end
        total++; if (sum !== exp_sum) begin bad_cnt++; $display("FAIL badaddr_checksum: got %h want %h", sum, exp_sum); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, bo; int lat; logic bf, ot, da, br, ba;
        addr_t[1] = 32'd9; drv_t[1] = rnd() | 32'h1; den_t[1] = 1'b1; wq_t[1] = 1'b1;
        @(posedge CLK); #1;
        total++; if (bsy[1] !== 1'b1) begin bad_cnt++; $display("FAIL abort_busy_before: got %b want 1", bsy[1]); end
        RESET = 1'b0; wq_t[1] = 1'b0; den_t[1] = 1'b0;
        #1;
        total++;
        if (bsy[1] !== 1'b0 || wdn[1] !== 1'b0 || rdn[1] !== 1'b0 || bus_v[1] !== 32'hFFFF_FFFF) begin
            bad_cnt++;
            $display("FAIL abort_async_outputs: busy %b write_dn %b read_dn %b bus %h want 0 0 0 ffffffff", bsy[1], wdn[1], rdn[1], bus_v[1]);
        end
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        xact(1, 1'b0, 32'd9, '0, rd, lat, bf, ot, da, bo, br, ba);
        total++; if (rd !== 32'h0) begin bad_cnt++; $display("FAIL abort_write_lost: got %h want 00000000", rd); end
        total++; if (lat !== 3 || ba !== 1'b0) begin bad_cnt++; $display("FAIL abort_read_after: latency %0d busy %b want 3 0", lat, ba); end
    endtask

    task automatic test_early_drop();
        logic [31:0] v, rd, bo; int n, lat; logic bf, ot, da, br, ba;
        v = rnd();
        addr_t[1] = 32'd10; drv_t[1] = v; den_t[1] = 1'b1; wq_t[1] = 1'b1;
        @(posedge CLK); #1;
        wq_t[1] = 1'b0; den_t[1] = 1'b0;
        n = 1;
        while (!wdn[1] && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        total++; if (n !== 3) begin bad_cnt++; $display("FAIL early_drop_dn: got %0d edges want 3", n); end
        @(posedge CLK); #1;
        total++; if (wdn[1] !== 1'b0) begin bad_cnt++; $display("FAIL early_drop_ack_exit: got %b want 0", wdn[1]); end
        @(posedge CLK); #1;
        model[1][10] = v;
        xact(1, 1'b0, 32'd10, '0, rd, lat, bf, ot, da, bo, br, ba);
        total++; if (rd !== v) begin bad_cnt++; $display("FAIL early_drop_commit: got %h want %h", rd, v); end
    endtask

    task automatic test_random();
        logic [31:0] a, v, rd, bo, want; int s, lat; bit wr; logic bf, ot, da, br, ba;
        for (int k = 0; k < 40; k++) begin
            s  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? (DEPTH + $urandom_range(0, 1000)) : $urandom_range(0, DEPTH - 1);
            v  = rnd();
            xact(s, wr, a, v, rd, lat, bf, ot, da, bo, br, ba);
            want = (a < DEPTH) ? model[s][a] : 32'h0;
            if (wr && a < DEPTH) model[s][a] = v;
            total++;
            if (lat !== exp_lat(s) || ot !== 1'b0 || da !== 1'b0 || ba !== 1'b0) begin
                bad_cnt++;
                $display("FAIL rand_handshake[%0d]: dut %0d latency %0d other %b dn_after %b busy %b want %0d 0 0 0", k, s, lat, ot, da, ba, exp_lat(s));
            end
            if (!wr) begin
                total++;
                if (rd !== want) begin bad_cnt++; $display("FAIL rand_read[%0d]: dut %0d addr %h got %h want %h", k, s, a, rd, want); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, last; logic prev;
        addr_t[0] = 32'd0; rq_t[0] = 1'b1; den_t[0] = 1'b0;
        n = 0; last = 0; prev = 1'b0;
        for (int c = 1; c <= 60 && n < 3; c++) begin
            @(posedge CLK); #1;
            total++;
            if (!rdn[0] && bus_v[0] !== 32'hFFFF_FFFF) begin bad_cnt++; $display("FAIL b2b_bus_driven[%0d]: got %h want ffffffff", c, bus_v[0]); end
            total++;
            if (rdn[0] && wdn[0]) begin bad_cnt++; $display("FAIL b2b_both_dn[%0d]: got 1 1 want not both", c); end
            if (rdn[0] && !prev) begin
                total++;
                if (bus_v[0] !== model[0][n]) begin bad_cnt++; $display("FAIL b2b_data[%0d]: got %h want %h", n, bus_v[0], model[0][n]); end
                total++;
                if ((n == 0 && c !== 2) || (n > 0 && c - last !== 4)) begin
                    bad_cnt++; $display("FAIL b2b_period[%0d]: edge %0d previous %0d want first at 2 then every 4", n, c, last);
                end
                last = c; n++;
                rq_t[0] = 1'b0;
            end else if (!rdn[0] && prev && n < 3) begin
                addr_t[0] = n; rq_t[0] = 1'b1;
            end
            prev = rdn[0];
        end
        total++; if (n !== 3) begin bad_cnt++; $display("FAIL b2b_timeout: got %0d reads want 3", n); end
        rq_t[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            total++;
            if (!rdn[0] && bus_v[0] !== 32'hFFFF_FFFF) begin bad_cnt++; $display("FAIL b2b_tail_bus[%0d]: got %h want ffffffff", c, bus_v[0]); end
        end
        total++; if (bsy[0] !== 1'b0) begin bad_cnt++; $display("FAIL b2b_final_idle: got %b want 0", bsy[0]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_basic();
        test_write_read();
        test_priority();
        test_bad_addr();
        test_reset_abort();
        test_early_drop();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the MemManager bus (addr / read_q / write_q / data / read_dn / write_dn).
- Answers the operand fetches and result writes that MemManager issues, replacing the behavioural memory model on the bench.
- Holds a word array, inserts programmable wait states, drives the shared tri-state data bus only while acknowledging a read.
- Uses a four-phase request/done handshake.

Parameters:
- DATA_W, 32, data bus / word width (matches `DATA_SIZE0+1).
- ADDR_W, 32, address bus width (matches `ADDR_SIZE0+1).
- DEPTH, 128, number of words implemented; valid addresses are 0..DEPTH-1.
- WAIT_CYC, 1, wait states inserted between request acceptance and done; 0..15 legal.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_W  word address from MemManager; stable while read_q/write_q is high.
- read_q  in  1  read request, level, held until read_dn is seen.
- write_q  in  1  write request, level, held until write_dn is seen.
- data  inout  DATA_W  shared bus; input on writes, driven by this block only while read_dn=1, else hi-Z.
- read_dn  out  1  read done; data valid while high.
- write_dn  out  1  write done; word committed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, read_dn=0, write_dn=0, busy=0, data hi-Z, wait counter=0. Memory contents are not cleared.
- Reset asserted mid-transaction aborts it immediately. A write not yet committed is lost.
- States:
  - IDLE: sample requests each posedge. read_q=1 -> latch addr, op=READ, go WAIT. Else write_q=1 -> latch addr and data, op=WRITE, go WAIT. Read has priority when both are high.
  - WAIT: counter counts 0..WAIT_CYC-1. When done (or immediately if WAIT_CYC=0), go ACK.
  - ACK:
    - READ: rdata_r <= mem[addr_l]; data driven from rdata_r; read_dn=1.
    - WRITE: mem[addr_l] <= wdata_l in the edge entering ACK; write_dn=1.
    - Held until the matching request drops.
  - ACK exit: at the first posedge with the matching request low, clear dn, release data to hi-Z, go REL.
  - REL: one idle cycle (bus turnaround), then IDLE. A request seen in REL is not accepted until IDLE.
- Latency:
  - Request accepted at edge k.
  - dn registered high at edge k+1+WAIT_CYC.
  - dn low one edge after the request is seen low.
  - Minimum transaction with WAIT_CYC=0: accept, ACK, drop, REL, IDLE = 4 cycles.
- Out-of-range address (addr >= DEPTH): read returns all zeros; write is discarded; handshake completes normally.
- Address index uses addr[clog2(DEPTH)-1:0] only after the range check; upper bits are never used to alias.
- Request dropped before dn (protocol violation): the transaction still completes to ACK. A write still commits. ACK then exits on the next edge since the request is already low.
- The opposite request asserted during ACK is ignored; it is served only after REL->IDLE, if still high.
- read_dn and write_dn are never high simultaneously.
- data is never driven when read_dn=0.

Optional Feature:
- Macro MEM_RESP_BADADDR_EN.
- Defined:
  - Extra output port bad_addr (1 bit).
  - Goes high together with read_dn/write_dn when the latched addr >= DEPTH, and low together with dn.
  - Reset value 0.
- Not defined: port absent; out-of-range behaviour otherwise identical (zeros on read, write discarded).

Test Plan:
- Preload mem[4]=32'h0000_00A5, WAIT_CYC=1. Raise read_q with addr=4 at edge 0 -> read_dn high at edge 2 with data=32'h0000_00A5. Drop read_q -> read_dn low and data=Z one edge later, busy low one edge after that.
- write_q with addr=7, data=32'h1234_5678 -> write_dn after 1+WAIT_CYC edges. Release. Read addr=7 -> 32'h1234_5678.
- read_q and write_q both high, addr=3 (mem[3]=32'hDEAD_BEEF) -> read served first (read_dn=1, data=32'hDEADBEEF), write_dn=0 throughout. Keep write_q, drop read_q -> write served after REL, mem[3] updated.
- Read addr=200 with DEPTH=128 -> data=0, read_dn completes. With MEM_RESP_BADADDR_EN, bad_addr=1 while read_dn=1. Write to addr=200 -> mem unchanged (checksum of all 128 words unchanged).
- Assert RESET=0 while in WAIT of a write to addr=9 (mem[9]=0) -> outputs immediately 0/Z, state IDLE, mem[9] still 0. A new read after release completes normally.
- WAIT_CYC=0 back-to-back reads of addr 0,1,2 with immediate request drop -> each transaction takes exactly 4 cycles. data never driven outside read_dn windows, checked every cycle.
